// File: rtl/pin_driver.sv
// pin_driver -- bidirectional pad output controller with bus turnaround and hold.
//
// Purpose: drives data_in onto a pad after a TURN_CYCLES gap with the output
// enable low, keeps the pad driven while req is high, then holds the last
// value for HOLD_CYCLES after req drops. All outputs are registered.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   level-sensitive drive request
//   data_in    in   [WIDTH] value to place on the pins
//   ack        out  one-cycle pulse on each entry into DRIVE
//   busy       out  high in every state except IDLE
//   dout       out  [WIDTH] registered pin data
//   oe         out  registered pin output enable
// Optional (macro PIN_DRIVER_CONFLICT_EN):
//   pin_sense  in   [WIDTH] filtered pin readback
//   conflict   out  sticky contention flag, cleared only by reset
module pin_driver #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] data_in,
`ifdef PIN_DRIVER_CONFLICT_EN
  input  logic [WIDTH-1:0] pin_sense,
  output logic             conflict,
`endif
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             oe
);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_DRIVE, S_HOLD} state_t;

  localparam logic [3:0] TURN_LD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;
  localparam logic [3:0] HOLD_LD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_oe, r_ack, r_busy;
  logic             w_oe_nxt;
  logic             w_req;    // request after conflict masking
  logic             w_abort;  // contention detected: drop to IDLE

`ifdef PIN_DRIVER_CONFLICT_EN
  logic       r_conflict;
  logic [1:0] r_stab;  // cycles dout has held its value while driven, saturates at 3

  assign w_req   = req & ~r_conflict;
  assign w_abort = r_oe && (r_stab == 2'd3) && (pin_sense != r_dout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict <= 1'b0;
      r_stab     <= 2'd0;
    end else begin
      if (w_abort) r_conflict <= 1'b1;
      if (!w_oe_nxt)
        r_stab <= 2'd0;
      else if (r_oe && (w_dout_nxt == r_dout)) begin
        if (r_stab != 2'd3) r_stab <= r_stab + 2'd1;
      end else
        r_stab <= 2'd1;  // first cycle showing a new value
    end
  end

  assign conflict = r_conflict;
`else
  assign w_req   = req;
  assign w_abort = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (TURN_CYCLES == 0) w_state_nxt = S_DRIVE;
          else begin
            w_state_nxt = S_TURN;
            w_cnt_nxt   = TURN_LD;
          end
        end
      end
      S_TURN: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0)
          w_state_nxt = S_DRIVE;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      S_DRIVE: begin
        if (!w_req) begin
          if (HOLD_CYCLES == 0) w_state_nxt = S_IDLE;
          else begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LD;
          end
        end
      end
      S_HOLD: begin
        // A new request resumes driving at once: the bus is still ours.
        if (w_req) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0)
          w_state_nxt = S_IDLE;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
    end

    w_oe_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_HOLD);
    case (w_state_nxt)
      S_DRIVE: w_dout_nxt = data_in;
      S_HOLD:  w_dout_nxt = r_dout;  // freeze last driven value
      default: w_dout_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dout  <= '0;
      r_oe    <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_oe    <= w_oe_nxt;
      r_ack   <= (w_state_nxt == S_DRIVE) && (r_state != S_DRIVE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign ack  = r_ack;
  assign busy = r_busy;
  assign dout = r_dout;
  assign oe   = r_oe;

endmodule

// File: tb/tb_pin_driver.sv
// Testbench for pin_driver with default parameters (WIDTH 8, TURN 2, HOLD 3).
// Each step drives inputs on the falling edge, pushes the outputs expected
// after the next rising edge into a scoreboard, and pops/compares them 1 ns
// after that edge.
module tb_pin_driver;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic [W-1:0] data_in;
  logic         ack, busy, oe;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PIN_DRIVER_CONFLICT_EN
  logic         sense_force = 1'b0;
  logic [W-1:0] sense_val   = '0;
  logic [W-1:0] pin_sense;
  logic         conflict;
  // The pad reads back what we drive unless a contention is being injected.
  assign pin_sense = sense_force ? sense_val : dout;
`endif

  pin_driver #(.WIDTH(W), .TURN_CYCLES(2), .HOLD_CYCLES(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data_in  (data_in),
`ifdef PIN_DRIVER_CONFLICT_EN
    .pin_sense(pin_sense),
    .conflict (conflict),
`endif
    .ack      (ack),
    .busy     (busy),
    .dout     (dout),
    .oe       (oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         req;
    logic [W-1:0] din;
    logic         oe, ack, busy;
    logic [W-1:0] dout;
    string        name;
  } vec_t;

  typedef struct {
    logic         oe, ack, busy;
    logic [W-1:0] dout;
    string        name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [W-1:0] d, input logic e_oe,
                     input logic e_ack, input logic e_busy, input logic [W-1:0] e_dout,
                     input string name);
    vec_t v;
    v.req = r; v.din = d; v.oe = e_oe; v.ack = e_ack; v.busy = e_busy;
    v.dout = e_dout; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard: empty queue when output expected");
      return;
    end
    e = sb.pop_front();
    chk($sformatf("%s.oe", e.name),   32'(oe),   32'(e.oe));
    chk($sformatf("%s.ack", e.name),  32'(ack),  32'(e.ack));
    chk($sformatf("%s.busy", e.name), 32'(busy), 32'(e.busy));
    chk($sformatf("%s.dout", e.name), 32'(dout), 32'(e.dout));
  endtask

  task automatic step(input logic r, input logic [W-1:0] d, input logic e_oe,
                      input logic e_ack, input logic e_busy, input logic [W-1:0] e_dout,
                      input string name);
    exp_t e;
    @(negedge clk);
    req = r; data_in = d;
    e.oe = e_oe; e.ack = e_ack; e.busy = e_busy; e.dout = e_dout; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    // Basic sequence: turnaround, drive, data change, hold, release.
    add(1, 8'hA5, 0, 0, 1, 8'h00, "a_turn1");
    add(1, 8'hA5, 0, 0, 1, 8'h00, "a_turn2");
    add(1, 8'hA5, 1, 1, 1, 8'hA5, "a_drive");
    add(1, 8'h3C, 1, 0, 1, 8'h3C, "a_data");
    add(0, 8'h3C, 1, 0, 1, 8'h3C, "a_hold1");
    add(0, 8'hFF, 1, 0, 1, 8'h3C, "a_hold2");
    add(0, 8'hFF, 1, 0, 1, 8'h3C, "a_hold3");
    add(0, 8'hFF, 0, 0, 0, 8'h00, "a_idle");
    // Re-request in the second hold cycle: straight back to DRIVE.
    add(1, 8'h11, 0, 0, 1, 8'h00, "b_turn1");
    add(1, 8'h11, 0, 0, 1, 8'h00, "b_turn2");
    add(1, 8'h22, 1, 1, 1, 8'h22, "b_drive");
    add(0, 8'h22, 1, 0, 1, 8'h22, "b_hold1");
    add(0, 8'h99, 1, 0, 1, 8'h22, "b_hold2");
    add(1, 8'h33, 1, 1, 1, 8'h33, "b_redrive");
    add(1, 8'h44, 1, 0, 1, 8'h44, "b_drive2");
    add(0, 8'h44, 1, 0, 1, 8'h44, "b_hold1b");
    add(0, 8'h44, 1, 0, 1, 8'h44, "b_hold2b");
    add(0, 8'h44, 1, 0, 1, 8'h44, "b_hold3b");
    add(0, 8'h44, 0, 0, 0, 8'h00, "b_idle");
    // One-cycle request pulse aborts in TURN.
    add(1, 8'h77, 0, 0, 1, 8'h00, "c_turn");
    add(0, 8'h77, 0, 0, 0, 8'h00, "c_abort");
    add(0, 8'h77, 0, 0, 0, 8'h00, "c_idle1");
    add(0, 8'h12, 0, 0, 0, 8'h00, "c_idle2");
    // Single-cycle DRIVE followed by the full hold.
    add(1, 8'h5A, 0, 0, 1, 8'h00, "d_turn1");
    add(1, 8'h5A, 0, 0, 1, 8'h00, "d_turn2");
    add(1, 8'h5A, 1, 1, 1, 8'h5A, "d_drive");
    add(0, 8'h00, 1, 0, 1, 8'h5A, "d_hold1");
    add(0, 8'h00, 1, 0, 1, 8'h5A, "d_hold2");
    add(0, 8'h00, 1, 0, 1, 8'h5A, "d_hold3");
    add(0, 8'h00, 0, 0, 0, 8'h00, "d_idle");

    reset = 1'b1; req = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.oe", 32'(oe), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.dout", 32'(dout), 32'd0);
`ifdef PIN_DRIVER_CONFLICT_EN
    chk("rst.conflict", 32'(conflict), 32'd0);
`endif
    reset = 1'b0;

    foreach (vecs[i])
      step(vecs[i].req, vecs[i].din, vecs[i].oe, vecs[i].ack, vecs[i].busy,
           vecs[i].dout, vecs[i].name);

    // Asynchronous reset in the middle of DRIVE, then a held request.
    step(1, 8'hA1, 0, 0, 1, 8'h00, "r_turn1");
    step(1, 8'hA1, 0, 0, 1, 8'h00, "r_turn2");
    step(1, 8'hA2, 1, 1, 1, 8'hA2, "r_drive");
    step(1, 8'hA3, 1, 0, 1, 8'hA3, "r_drive2");
    #2;
    reset = 1'b1;
    #1;  // still before the next rising edge
    chk("r_async.oe", 32'(oe), 32'd0);
    chk("r_async.dout", 32'(dout), 32'd0);
    chk("r_async.ack", 32'(ack), 32'd0);
    chk("r_async.busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 8'hB1, 0, 0, 1, 8'h00, "r_post_turn1");
    step(1, 8'hB1, 0, 0, 1, 8'h00, "r_post_turn2");
    step(1, 8'hB1, 1, 1, 1, 8'hB1, "r_post_drive");
    step(0, 8'hB1, 1, 0, 1, 8'hB1, "r_post_hold1");
    step(0, 8'hB1, 1, 0, 1, 8'hB1, "r_post_hold2");
    step(0, 8'hB1, 1, 0, 1, 8'hB1, "r_post_hold3");
    step(0, 8'hB1, 0, 0, 0, 8'h00, "r_post_idle");

`ifdef PIN_DRIVER_CONFLICT_EN
    // Readback disagrees from the start; only a value stable for 3 driven
    // cycles may flag it.
    sense_force = 1'b1;
    sense_val   = 8'h54;
    step(1, 8'h55, 0, 0, 1, 8'h00, "x_turn1");
    step(1, 8'h55, 0, 0, 1, 8'h00, "x_turn2");
    step(1, 8'h55, 1, 1, 1, 8'h55, "x_drive1");
    step(1, 8'h55, 1, 0, 1, 8'h55, "x_drive2");
    step(1, 8'h55, 1, 0, 1, 8'h55, "x_drive3");
    chk("x_pre.conflict", 32'(conflict), 32'd0);
    step(1, 8'h55, 0, 0, 0, 8'h00, "x_abort");
    chk("x_abort.conflict", 32'(conflict), 32'd1);
    step(1, 8'h55, 0, 0, 0, 8'h00, "x_ignore1");
    step(1, 8'h55, 0, 0, 0, 8'h00, "x_ignore2");
    chk("x_sticky.conflict", 32'(conflict), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("x_rst.conflict", 32'(conflict), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sense_force = 1'b0;
    step(1, 8'h55, 0, 0, 1, 8'h00, "x_resume_turn");
`endif

    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard: %0d entries left unchecked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
